lc_otp_prog_req: RTL and testbench
==================================

Name: lc_otp_prog_req

Overview:
Upstream requester for the OTP life cycle interface (LCI) stage. It accepts a transition command (target state word and target count word) from the life cycle controller FSM and builds the packed OTP partition image. It drives the level-sensitive lc_req/lc_data handshake into OTP and holds it stable until the single-cycle lc_ack. It returns one done/error pulse to the LC FSM, and supervises the transaction with a timeout and escalation.

Parameters:
LcStateWidth, 320, width of target life cycle state word in bits
LcCountWidth, 384, width of target transition count word in bits
TimeoutCycles, 65535, max cycles in ReqSt without lc_ack_i before declaring timeout (1..65535)

Ports:
clk_i  in  1  clock
rst_ni  in  1  async active-low reset
escalate_en_i  in  lc_ctrl_pkg::lc_tx_t  any value != Off forces terminal error
trans_req_i  in  1  single-cycle transition command strobe
trans_state_i  in  LcStateWidth  target state word, sampled with trans_req_i
trans_cnt_i  in  LcCountWidth  target count word, sampled with trans_req_i
trans_busy_o  out  1  high while a request is outstanding
trans_done_o  out  1  one-cycle completion pulse
trans_err_o  out  1  valid with trans_done_o: OTP or timeout error
trans_timeout_o  out  1  sticky: timeout occurred
fsm_err_o  out  1  sticky: terminal error state reached
lc_req_o  out  1  request to OTP LCI (level)
lc_data_o  out  LcStateWidth+LcCountWidth  packed image {cnt, state}, state in LSBs
lc_ack_i  in  1  OTP completion pulse
lc_err_i  in  1  OTP programming error, valid with lc_ack_i

Behaviour:
- Reset values: all outputs 0; the data register is 0; the timeout counter is 0; the state is IdleSt.
- FSM states: IdleSt, ReqSt, ErrorSt. The state is sparse-encoded with minimum Hamming distance 3, held in a prim_flop so encoding is not optimised. An illegal encoding goes to ErrorSt.
- IdleSt:
  - When trans_req_i is high, latch {trans_cnt_i, trans_state_i} into the data register, clear the timeout counter, and go to ReqSt.
  - lc_req_o rises in the cycle after the strobe (one-cycle latency).
- ReqSt:
  - lc_req_o=1 and trans_busy_o=1.
  - lc_data_o comes from the register and is stable for the whole state.
  - The counter increments each cycle and saturates; it does not wrap.
  - On lc_ack_i:
    - Pulse trans_done_o with trans_err_o=lc_err_i in the same cycle.
    - If lc_err_i=0, go to IdleSt.
    - If lc_err_i=1, go to ErrorSt.
  - Timeout: if the counter reaches TimeoutCycles-1 with no ack, take the timeout action in that cycle:
    - pulse trans_done_o=1 and trans_err_o=1;
    - set trans_timeout_o;
    - go to ErrorSt.
  - An ack arriving in the timeout cycle wins: it is treated as a normal ack and no timeout is flagged.
- trans_req_i while in ReqSt or ErrorSt is ignored: no relatch and no pulse.
- lc_ack_i outside ReqSt is ignored.
- ErrorSt:
  - Terminal until reset.
  - lc_req_o=0, fsm_err_o=1, trans_busy_o=0.
  - lc_data_o is driven to 0.
- Escalation overrides every state:
  - next state is ErrorSt; lc_req_o is deasserted in the following cycle.
  - If escalation arrives while in ReqSt, pulse trans_done_o=1 with trans_err_o=1 once.
  - Escalation simultaneous with lc_ack_i: escalation wins and trans_err_o=1.
- lc_data_o is 0 whenever lc_req_o=0.
- Reset asserted mid-request: outputs drop asynchronously. The OTP side tolerates an abandoned request because its own reset is shared.

Decomposition:
- Shared package (lc_ctrl_pkg):
  - LcStateWidth and LcCountWidth;
  - the packed image typedef (lc_otp_prog_data_t, a struct {cnt, state});
  - the TimeoutCycles default.
- The FSM state enum stays local to the module.
- One sub-module is natural: lc_otp_prog_timer, a saturating counter with clear/enable and a terminal-count flag, reusable by other LC-side requesters.

Test Plan:
1. Basic request:
   - Stimulus: trans_req_i pulse with state=0x...A5, cnt=0x...01; OTP acks 10 cycles after lc_req_o rises with lc_err_i=0.
   - Required: lc_req_o high for exactly 10 cycles; lc_data_o = {0x..01, 0x..A5} and stable; trans_done_o=1 and trans_err_o=0 in the ack cycle; back in IdleSt.
2. OTP error:
   - Stimulus: ack with lc_err_i=1.
   - Required: done and err pulse together; fsm_err_o=1 from the next cycle; a later trans_req_i produces no lc_req_o.
3. Timeout:
   - Stimulus: TimeoutCycles=8, no ack.
   - Required: on cycle 8 of ReqSt, trans_done_o=1, trans_err_o=1, trans_timeout_o=1; lc_req_o low in the next cycle.
4. Ack on the terminal-count cycle:
   - Stimulus: TimeoutCycles=8, ack with lc_err_i=0 on the terminal-count cycle.
   - Required: trans_err_o=0, trans_timeout_o stays 0, FSM returns to IdleSt.
5. Escalation during request:
   - Stimulus: escalate_en_i=On mid-ReqSt.
   - Required: single done/err pulse; lc_req_o and lc_data_o are 0 from the next cycle; a later ack is ignored.
6. Reset and back-to-back behaviour:
   - Stimulus: assert rst_ni low mid-ReqSt.
   - Required: all outputs 0 immediately.
   - Stimulus: a second trans_req_i issued while busy.
   - Required: ignored, and the data register is unchanged.

Source files
------------

// File: rtl/lc_ctrl_pkg.sv
// Shared life cycle controller definitions: word widths, the packed OTP
// programming image, the escalation encoding and the default timeout.
package lc_ctrl_pkg;

  localparam int LcStateWidth = 320;
  localparam int LcCountWidth = 384;
  localparam int LcDataWidth  = LcStateWidth + LcCountWidth;

  // Default request supervision window and the counter width that covers it.
  localparam int TimeoutCyclesDefault = 65535;
  localparam int TimerWidth           = 16;

  // Multi-bit escalation signal; anything other than Off counts as asserted.
  typedef enum logic [3:0] {
    On  = 4'b0101,
    Off = 4'b1010
  } lc_tx_t;

  // Image written into the OTP life cycle partition, state word in the LSBs.
  typedef struct packed {
    logic [LcCountWidth-1:0] cnt;
    logic [LcStateWidth-1:0] state;
  } lc_otp_prog_data_t;

endpackage

// File: rtl/lc_otp_prog_timer.sv
// Saturating cycle counter with synchronous clear and count enable. The
// terminal-count flag is high while the count sits at Limit-1, and the count
// never moves past that value.
module lc_otp_prog_timer
  import lc_ctrl_pkg::*;
#(
  parameter int Width = TimerWidth,
  parameter int Limit = TimeoutCyclesDefault
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [Width-1:0] LastCount = Width'(Limit - 1);

  logic [Width-1:0] count;

  // Increment that sticks at the terminal count instead of wrapping.
  function automatic logic [Width-1:0] sat_inc(input logic [Width-1:0] v);
    return (v == LastCount) ? v : v + Width'(1);
  endfunction

  // Counter register: clear has priority over enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= sat_inc(count);
    end
  end

  assign tc = (count == LastCount);

endmodule

// File: rtl/lc_otp_prog_req.sv
// Requester towards the OTP life cycle interface. Latches a transition
// command into the packed partition image, holds lc_req/lc_data until OTP
// acknowledges, returns a single done/error pulse and supervises the
// transaction with a timeout and escalation.
module lc_otp_prog_req
  import lc_ctrl_pkg::*;
#(
  parameter int TimeoutCycles = TimeoutCyclesDefault
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  lc_tx_t                  escalate_en_i,
  input  logic                    trans_req_i,
  input  logic [LcStateWidth-1:0] trans_state_i,
  input  logic [LcCountWidth-1:0] trans_cnt_i,
  output logic                    trans_busy_o,
  output logic                    trans_done_o,
  output logic                    trans_err_o,
  output logic                    trans_timeout_o,
  output logic                    fsm_err_o,
  output logic                    lc_req_o,
  output logic [LcDataWidth-1:0]  lc_data_o,
  input  logic                    lc_ack_i,
  input  logic                    lc_err_i
);

  // Sparse encoding, pairwise Hamming distance >= 3, so that a single upset
  // cannot turn one legal state into another; illegal codes fall into ErrorSt.
  typedef enum logic [4:0] {
    IdleSt  = 5'b01110,
    ReqSt   = 5'b10101,
    ErrorSt = 5'b11011
  } state_e;

  state_e            fsm_state;
  state_e            fsm_next;
  lc_otp_prog_data_t data;

  logic esc;
  logic in_req;
  logic latch;
  logic tc;
  logic timeout_evt;
  logic done;
  logic err;

  logic lc_req;
  logic busy;
  logic fsm_err;
  logic timeout;

  lc_otp_prog_timer #(
    .Width (TimerWidth),
    .Limit (TimeoutCycles)
  ) u_timer (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .clr   (latch),
    .en    (in_req),
    .tc    (tc)
  );

  // Event decode and next-state selection; escalation overrides everything,
  // and an ack in the terminal-count cycle beats the timeout.
  always_comb begin
    esc         = (escalate_en_i != Off);
    in_req      = (fsm_state == ReqSt);
    latch       = (fsm_state == IdleSt) && trans_req_i && !esc;
    timeout_evt = in_req && tc && !lc_ack_i && !esc;
    done        = in_req && (lc_ack_i || tc || esc);
    err         = in_req && (esc || (lc_ack_i ? lc_err_i : tc));

    fsm_next = fsm_state;
    case (fsm_state)
      IdleSt: begin
        if (latch) fsm_next = ReqSt;
      end
      ReqSt: begin
        if (timeout_evt || (lc_ack_i && lc_err_i)) begin
          fsm_next = ErrorSt;
        end else if (lc_ack_i) begin
          fsm_next = IdleSt;
        end
      end
      ErrorSt: fsm_next = ErrorSt;
      default: fsm_next = ErrorSt;
    endcase
    if (esc) fsm_next = ErrorSt;
  end

  // State register with registered handshake/status outputs and image latch.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fsm_state <= IdleSt;
      lc_req    <= 1'b0;
      busy      <= 1'b0;
      fsm_err   <= 1'b0;
      timeout   <= 1'b0;
      data      <= '0;
    end else begin
      fsm_state <= fsm_next;
      lc_req    <= (fsm_next == ReqSt);
      busy      <= (fsm_next == ReqSt);
      fsm_err   <= fsm_err | (fsm_next == ErrorSt);
      timeout   <= timeout | timeout_evt;
      if (latch) begin
        data <= {trans_cnt_i, trans_state_i};
      end
    end
  end

  assign trans_busy_o    = busy;
  assign trans_done_o    = done;
  assign trans_err_o     = err;
  // The timeout flag shows up already in the cycle the timeout is taken.
  assign trans_timeout_o = timeout | timeout_evt;
  assign fsm_err_o       = fsm_err;
  assign lc_req_o        = lc_req;
  // The image is only visible on the bus while the request is raised.
  assign lc_data_o       = lc_req ? data : '0;

endmodule

// File: tb/tb_lc_otp_prog_req.sv
// Directed bench for lc_otp_prog_req: one instance with the default timeout
// and one with an 8-cycle timeout, driven from shared stimulus.
module tb_lc_otp_prog_req;
  import lc_ctrl_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  lc_tx_t                  esc_en = Off;
  logic                    t_req = 1'b0;
  logic [LcStateWidth-1:0] t_state = '0;
  logic [LcCountWidth-1:0] t_cnt = '0;
  logic                    ack = 1'b0;
  logic                    ack_err = 1'b0;

  logic                   busy_a, done_a, err_a, to_a, ferr_a, req_a;
  logic [LcDataWidth-1:0] data_a;
  logic                   busy_b, done_b, err_b, to_b, ferr_b, req_b;
  logic [LcDataWidth-1:0] data_b;

  logic [LcDataWidth-1:0] exp_img;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  lc_otp_prog_req dut_a (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .escalate_en_i   (esc_en),
    .trans_req_i     (t_req),
    .trans_state_i   (t_state),
    .trans_cnt_i     (t_cnt),
    .trans_busy_o    (busy_a),
    .trans_done_o    (done_a),
    .trans_err_o     (err_a),
    .trans_timeout_o (to_a),
    .fsm_err_o       (ferr_a),
    .lc_req_o        (req_a),
    .lc_data_o       (data_a),
    .lc_ack_i        (ack),
    .lc_err_i        (ack_err)
  );

  lc_otp_prog_req #(.TimeoutCycles(8)) dut_b (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .escalate_en_i   (esc_en),
    .trans_req_i     (t_req),
    .trans_state_i   (t_state),
    .trans_cnt_i     (t_cnt),
    .trans_busy_o    (busy_b),
    .trans_done_o    (done_b),
    .trans_err_o     (err_b),
    .trans_timeout_o (to_b),
    .fsm_err_o       (ferr_b),
    .lc_req_o        (req_b),
    .lc_data_o       (data_b),
    .lc_ack_i        (ack),
    .lc_err_i        (ack_err)
  );

  task automatic chk_eq(input string tag, input logic [LcDataWidth-1:0] got,
                        input logic [LcDataWidth-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    esc_en = Off;
    t_req  = 1'b0;
    ack    = 1'b0;
    ack_err = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  // Issue a one-cycle command strobe; afterwards the inputs are scrambled so
  // that any late relatch would show up on lc_data.
  task automatic do_request(input logic [LcStateWidth-1:0] s,
                            input logic [LcCountWidth-1:0] c);
    t_state = s;
    t_cnt   = c;
    t_req   = 1'b1;
    cyc();
    t_req   = 1'b0;
    t_state = {LcStateWidth{1'b1}};
    t_cnt   = {LcCountWidth{1'b1}};
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    cyc();
    #1;
    chk_eq("rst_req", req_a, 0);
    chk_eq("rst_busy", busy_a, 0);
    chk_eq("rst_done", done_a, 0);
    chk_eq("rst_err", err_a, 0);
    chk_eq("rst_to", to_a, 0);
    chk_eq("rst_ferr", ferr_a, 0);
    chk_eq("rst_data", data_a, 0);
    rst_n = 1'b1;
    cyc();

    // 1: basic request, ack in the 10th cycle of lc_req
    exp_img = {384'h01, 320'hA5};
    do_request(320'hA5, 384'h01);
    for (int i = 1; i <= 10; i++) begin
      ack = (i == 10);
      #1;
      chk_eq("t1_req", req_a, 1);
      chk_eq("t1_busy", busy_a, 1);
      chk_eq("t1_data", data_a, exp_img);
      chk_eq("t1_done", done_a, (i == 10));
      if (i == 10) chk_eq("t1_err", err_a, 0);
      cyc();
    end
    ack = 1'b0;
    #1;
    chk_eq("t1_req_drop", req_a, 0);
    chk_eq("t1_busy_drop", busy_a, 0);
    chk_eq("t1_data_drop", data_a, 0);
    chk_eq("t1_ferr", ferr_a, 0);

    // 2: OTP error (dut_a is idle again, so a new request must start)
    exp_img = {384'h02, 320'h3C};
    do_request(320'h3C, 384'h02);
    #1;
    chk_eq("t2_req", req_a, 1);
    chk_eq("t2_data", data_a, exp_img);
    cyc();
    ack = 1'b1;
    ack_err = 1'b1;
    #1;
    chk_eq("t2_done", done_a, 1);
    chk_eq("t2_err", err_a, 1);
    cyc();
    ack = 1'b0;
    ack_err = 1'b0;
    #1;
    chk_eq("t2_ferr", ferr_a, 1);
    chk_eq("t2_req_low", req_a, 0);
    chk_eq("t2_data_low", data_a, 0);
    do_request(320'h11, 384'h22);
    cyc();
    #1;
    chk_eq("t2_noreq", req_a, 0);
    chk_eq("t2_nodone", done_a, 0);

    // 3: timeout on cycle 8 of ReqSt (dut_b)
    do_reset();
    do_request(320'h5, 384'h6);
    for (int i = 1; i <= 8; i++) begin
      #1;
      chk_eq("t3_req", req_b, 1);
      chk_eq("t3_done", done_b, (i == 8));
      chk_eq("t3_to", to_b, (i == 8));
      if (i == 8) chk_eq("t3_err", err_b, 1);
      cyc();
    end
    #1;
    chk_eq("t3_req_low", req_b, 0);
    chk_eq("t3_to_sticky", to_b, 1);
    chk_eq("t3_ferr", ferr_b, 1);
    chk_eq("t3_done_low", done_b, 0);

    // 4: ack wins in the terminal-count cycle (dut_b)
    do_reset();
    do_request(320'h7, 384'h8);
    for (int i = 1; i < 8; i++) cyc();
    ack = 1'b1;
    #1;
    chk_eq("t4_done", done_b, 1);
    chk_eq("t4_err", err_b, 0);
    chk_eq("t4_to", to_b, 0);
    cyc();
    ack = 1'b0;
    #1;
    chk_eq("t4_to_after", to_b, 0);
    chk_eq("t4_ferr", ferr_b, 0);
    chk_eq("t4_req_low", req_b, 0);
    do_request(320'h9, 384'hA);
    #1;
    chk_eq("t4_idle_again", req_b, 1);

    // 5: escalation mid-request (dut_a)
    do_reset();
    do_request(320'hB, 384'hC);
    cyc();
    cyc();
    esc_en = On;
    #1;
    chk_eq("t5_done", done_a, 1);
    chk_eq("t5_err", err_a, 1);
    cyc();
    #1;
    chk_eq("t5_done_once", done_a, 0);
    chk_eq("t5_req_low", req_a, 0);
    chk_eq("t5_data_low", data_a, 0);
    chk_eq("t5_ferr", ferr_a, 1);
    esc_en = Off;
    ack = 1'b1;
    #1;
    chk_eq("t5_ack_ignored", done_a, 0);
    cyc();
    ack = 1'b0;
    #1;
    chk_eq("t5_still_err", ferr_a, 1);
    chk_eq("t5_still_noreq", req_a, 0);

    // 5b: non-Off escalation code together with a clean ack
    do_reset();
    do_request(320'hD, 384'hE);
    cyc();
    esc_en = lc_tx_t'(4'h0);
    ack = 1'b1;
    #1;
    chk_eq("t5b_done", done_a, 1);
    chk_eq("t5b_err", err_a, 1);
    cyc();
    esc_en = Off;
    ack = 1'b0;
    #1;
    chk_eq("t5b_ferr", ferr_a, 1);

    // 6: request while busy is ignored, then reset mid-request
    do_reset();
    exp_img = {384'h05, 320'h77};
    do_request(320'h77, 384'h05);
    t_state = 320'hFF;
    t_cnt   = 384'hEE;
    t_req   = 1'b1;
    cyc();
    t_req = 1'b0;
    #1;
    chk_eq("t6_req", req_a, 1);
    chk_eq("t6_norelatch", data_a, exp_img);
    chk_eq("t6_nodone", done_a, 0);
    rst_n = 1'b0;
    #1;
    chk_eq("t6_rst_req", req_a, 0);
    chk_eq("t6_rst_busy", busy_a, 0);
    chk_eq("t6_rst_data", data_a, 0);
    chk_eq("t6_rst_done", done_a, 0);
    cyc();
    rst_n = 1'b1;
    cyc();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
